tree_node_collector: RTL and testbench

//   Fan-in node of the generated instance tree. A parent node fans out to NUM_CHILDREN

---
 rtl/tree_node_collector.sv | 125 ++++++++++++
 tb/tb_tree_node_collector.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_node_collector.sv
// Merges NUM_CHILDREN child return streams into one upstream stream tagged with the source index.
// Latency 1 through a single output register; packet-granular round-robin; child_ready follows upstream space.
module tree_node_collector #(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int IDX_W        = 3,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  input  logic [NUM_CHILDREN-1:0]        child_last,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           up_valid,
  output logic [DATA_W-1:0]              up_data,
  output logic                           up_last,
  output logic [IDX_W-1:0]               up_idx,
  input  logic                           up_ready,
  output logic [CNT_W-1:0]               pkt_cnt,
  output logic                           locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic               up_valid_q, up_valid_d;
  logic [DATA_W-1:0]  up_data_q, up_data_d;
  logic               up_last_q, up_last_d;
  logic [IDX_W-1:0]   up_idx_q, up_idx_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic               can_load;
  logic               found;
  logic               xfer;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;
  int                 sel;
  int                 cand;

  always_comb begin
    can_load = !up_valid_q || up_ready;
    found    = 1'b0;
    sel      = 0;
    cand     = 0;
    if (state_q == LOCKED) begin
      // Mid-packet the locked child owns the slot, whatever the others present.
      found = 1'b1;
      sel   = int'(lock_idx_q);
    end else begin
      for (int k = 0; k < NUM_CHILDREN; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NUM_CHILDREN) cand = cand - NUM_CHILDREN;
        if (!found && child_valid[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end

    child_ready = '0;
    if (rst_n && found && can_load) child_ready[sel] = 1'b1;
    xfer     = rst_n && found && can_load && child_valid[sel];
    sel_data = child_data[sel*DATA_W +: DATA_W];
    sel_last = child_last[sel];

    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    up_valid_d = up_valid_q;
    up_data_d  = up_data_q;
    up_last_d  = up_last_q;
    up_idx_d   = up_idx_q;
    pkt_cnt_d  = pkt_cnt_q;

    if (xfer) begin
      up_valid_d = 1'b1;
      up_data_d  = sel_data;
      up_last_d  = sel_last;
      up_idx_d   = IDX_W'(sel);
      if (sel_last) begin
        state_d   = IDLE;
        rr_ptr_d  = (sel == NUM_CHILDREN - 1) ? '0 : IDX_W'(sel + 1);
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end else begin
        state_d    = LOCKED;
        lock_idx_d = IDX_W'(sel);
      end
    end else if (up_ready) begin
      up_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      up_valid_q <= 1'b0;
      up_data_q  <= '0;
      up_last_q  <= 1'b0;
      up_idx_q   <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      up_valid_q <= up_valid_d;
      up_data_q  <= up_data_d;
      up_last_q  <= up_last_d;
      up_idx_q   <= up_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign up_valid = up_valid_q;
  assign up_data  = up_data_q;
  assign up_last  = up_last_q;
  assign up_idx   = up_idx_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_tree_node_collector.sv
// Randomized bench for tree_node_collector: per-child packet scoreboard plus a rule-level arbitration model.
module tb_tree_node_collector;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int IW = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    child_valid, child_last, child_ready;
  logic [N*DW-1:0] child_data;
  logic            up_valid, up_last, up_ready, locked;
  logic [DW-1:0]   up_data;
  logic [IW-1:0]   up_idx;
  logic [CW-1:0]   pkt_cnt;

  tree_node_collector #(.NUM_CHILDREN(N), .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .child_valid(child_valid), .child_data(child_data), .child_last(child_last),
    .child_ready(child_ready),
    .up_valid(up_valid), .up_data(up_data), .up_last(up_last), .up_idx(up_idx),
    .up_ready(up_ready), .pkt_cnt(pkt_cnt), .locked(locked)
  );

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];
  int    obs_idx [$];

  int checks = 0;
  int errors = 0;

  int p_valid = 100;
  int p_ready = 100;
  bit force_stall = 1'b0;

  logic [N-1:0] hs_n = '0;

  int          m_ptr = 0;
  bit          m_locked = 1'b0;
  int          m_lock = 0;
  logic [CW-1:0] m_cnt = '0;
  bit          m_vld = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit          m_last = 1'b0;
  int          m_idx = 0;
  int          up_cur = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    int g;
    bit can;
    bit xf;
    logic [N-1:0] exp_rdy;
    beat_t bt;
    chk("up_valid", {31'b0, up_valid}, {31'b0, m_vld});
    if (m_vld) begin
      chk("up_data", {16'b0, up_data}, {16'b0, m_data});
      chk("up_last", {31'b0, up_last}, {31'b0, m_last});
      chk("up_idx", {29'b0, up_idx}, m_idx);
    end
    chk("pkt_cnt", {16'b0, pkt_cnt}, {16'b0, m_cnt});
    chk("locked", {31'b0, locked}, {31'b0, m_locked});

    can = !m_vld || up_ready;
    g = -1;
    exp_rdy = '0;
    if (rst_n) begin
      if (m_locked) g = m_lock;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && child_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0 && can) exp_rdy[g] = 1'b1;
    end
    chk("child_ready", {27'b0, child_ready}, {27'b0, exp_rdy});
    hs_n = child_valid & child_ready;

    if (rst_n && up_valid && up_ready) begin
      obs_idx.push_back(int'(up_idx));
      if (up_cur >= 0) chk("no_interleave", {29'b0, up_idx}, up_cur);
      up_cur = up_last ? -1 : int'(up_idx);
      checks++;
      if (exp_q[up_idx].size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=child%0d data=%0h required=no_beat", up_idx, up_data);
      end else begin
        checks--;
        bt = exp_q[up_idx].pop_front();
        chk("sb_data", {16'b0, up_data}, {16'b0, bt.data});
        chk("sb_last", {31'b0, up_last}, {31'b0, bt.last});
      end
    end

    if (!rst_n) begin
      m_ptr = 0; m_locked = 1'b0; m_lock = 0; m_cnt = '0;
      m_vld = 1'b0; m_data = '0; m_last = 1'b0; m_idx = 0; up_cur = -1;
    end else begin
      xf = (g >= 0) && can && child_valid[g];
      if (xf) begin
        m_vld  = 1'b1;
        m_data = child_data[g*DW +: DW];
        m_last = child_last[g];
        m_idx  = g;
        if (child_last[g]) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
          m_cnt    = m_cnt + 1'b1;
        end else begin
          m_locked = 1'b1;
          m_lock   = g;
        end
      end else if (up_ready) begin
        m_vld = 1'b0;
      end
    end
  end

  task automatic drive_children();
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() == 0) child_valid[c] = 1'b0;
      else if (!(child_valid[c] && !hs_n[c])) child_valid[c] = ($urandom_range(99) < p_valid);
      if (src_q[c].size() > 0) begin
        child_data[c*DW +: DW] = src_q[c][0].data;
        child_last[c]          = src_q[c][0].last;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++)
      if (hs_n[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    drive_children();
    up_ready = force_stall ? 1'b0 : ($urandom_range(99) < p_ready);
  endtask

  task automatic push_pkt(input int c, input int len, input logic [DW-1:0] d0, input bit rnd);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = rnd ? DW'($urandom) : d0 + DW'(b);
      bt.last = (b == len - 1);
      src_q[c].push_back(bt);
      exp_q[c].push_back(bt);
    end
  endtask

  function automatic bit busy();
    busy = up_valid;
    for (int c = 0; c < N; c++)
      if (src_q[c].size() != 0 || exp_q[c].size() != 0) busy = 1'b1;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin tick(); n++; end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s_timeout actual=busy_after_%0d_cycles required=drained", name, budget);
    end
  endtask

  task automatic do_reset(input int cyc, input bit all_valid);
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) begin src_q[c].delete(); exp_q[c].delete(); end
    child_valid = all_valid ? '1 : '0;
    repeat (cyc) @(posedge clk);
    #1;
    rst_n = 1'b1;
    child_valid = '0;
    hs_n = '0;
    drive_children();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    child_valid = '1;
    child_data = {N{16'h1234}};
    child_last = '1;
    up_ready = 1'b1;

    // Reset with every child requesting
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    child_valid = '0;
    tick();
    chk("reset_pkt_cnt", {16'b0, pkt_cnt}, 32'd0);
    chk("reset_up_valid", {31'b0, up_valid}, 32'd0);

    // Single beat from child 3
    p_valid = 100; p_ready = 100;
    push_pkt(3, 1, 16'hA5A5, 1'b0);
    drive_children();
    n = 0;
    while (!up_valid && n < 20) begin tick(); n++; end
    chk("single_valid", {31'b0, up_valid}, 32'd1);
    chk("single_data", {16'b0, up_data}, 32'hA5A5);
    chk("single_idx", {29'b0, up_idx}, 32'd3);
    chk("single_last", {31'b0, up_last}, 32'd1);
    chk("single_cnt", {16'b0, pkt_cnt}, 32'd1);
    drain("single", 50);

    // Round-robin with all children saturated
    do_reset(2, 1'b0);
    obs_idx.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) push_pkt(c, 1, 16'h0, 1'b1);
    drive_children();
    drain("rr", 100);
    chk("rr_len", obs_idx.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < obs_idx.size()) chk("rr_seq", obs_idx[i], i % N);

    // Lock: 3-beat packet from child 1 while child 2 waits
    obs_idx.delete();
    push_pkt(1, 3, 16'h1000, 1'b0);
    push_pkt(2, 1, 16'h2000, 1'b0);
    drive_children();
    drain("lock", 100);
    chk("lock_len", obs_idx.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < obs_idx.size()) chk("lock_seq", obs_idx[i], (i < 3) ? 1 : 2);

    // Random traffic with a forced 4-cycle upstream stall mid-stream
    p_valid = 60; p_ready = 70;
    for (int p = 0; p < 300; p++) begin
      push_pkt($urandom_range(N - 1), $urandom_range(4, 1), 16'h0, 1'b1);
      drive_children();
      if (p == 150) begin
        force_stall = 1'b1;
        repeat (4) tick();
        force_stall = 1'b0;
      end
      repeat ($urandom_range(3, 1)) tick();
    end
    drain("random", 4000);

    // Counter wrap after 65536 packets
    do_reset(1, 1'b0);
    p_valid = 100; p_ready = 100;
    for (int c = 0; c < N; c++)
      for (int i = 0; i < 65536 / N; i++) push_pkt(c, 1, 16'h0, 1'b1);
    push_pkt(0, 1, 16'h0, 1'b1);
    drive_children();
    drain("wrap", 70000);
    chk("wrap_cnt", {16'b0, pkt_cnt}, 32'd0);

    // Reset in the middle of a packet from child 4
    push_pkt(4, 4, 16'h4000, 1'b0);
    drive_children();
    n = 0;
    while (!locked && n < 20) begin tick(); n++; end
    chk("mid_locked", {31'b0, locked}, 32'd1);
    do_reset(2, 1'b0);
    chk("post_reset_locked", {31'b0, locked}, 32'd0);
    chk("post_reset_valid", {31'b0, up_valid}, 32'd0);
    push_pkt(4, 1, 16'h4444, 1'b0);
    push_pkt(0, 1, 16'h0000, 1'b0);
    drive_children();
    n = 0;
    while (!up_valid && n < 20) begin tick(); n++; end
    chk("post_reset_grant", {29'b0, up_idx}, 32'd0);
    drain("post_reset", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
